// File: rtl/wb_bus_ctrl.sv
`default_nettype none
// ======================================================================
// wb_bus_ctrl : Wishbone classic decode and sequencing with slave timeout.
// Optional WB_BUS_CTRL_STATS_EN adds err_count/err_addr.    Rev 1.0
// ======================================================================
module wb_bus_ctrl #(
  parameter int NUM_SLV     = 4,
  parameter int SLOT_LSB    = 24,
  parameter int SLOT_BITS   = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic                   m_we_i,
  input  logic [31:0]            m_adr_i,
  input  logic [31:0]            m_dat_i,
  input  logic [3:0]             m_sel_i,
  output logic [31:0]            m_dat_o,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic                   m_rty_o,
  output logic [NUM_SLV-1:0]     s_cyc_o,
  output logic [NUM_SLV-1:0]     s_stb_o,
  output logic                   s_we_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [3:0]             s_sel_o,
  input  logic [32*NUM_SLV-1:0]  s_dat_i,
  input  logic [NUM_SLV-1:0]     s_ack_i,
  input  logic [NUM_SLV-1:0]     s_err_i,
  input  logic [NUM_SLV-1:0]     s_rty_i
`ifdef WB_BUS_CTRL_STATS_EN
  ,
  output logic [15:0]            err_count,
  output logic [31:0]            err_addr
`endif
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state;
  logic [SLOT_BITS-1:0]   slot;
  logic [15:0]            cnt;
  logic [31:0]            slot_ext;
  logic [NUM_SLV-1:0]     dec_sel;
  logic                   mapped;
  logic                   hit_ack;
  logic                   hit_err;
  logic                   hit_rty;
  logic [31:0]            rd_data;

  assign slot_ext = 32'(slot);

  // An out-of-range slot decodes to an all-zero select, which marks it unmapped.
  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_sel[i] = (slot_ext == 32'(i));
    end
  end

  assign mapped  = |dec_sel;
  assign hit_ack = |(s_ack_i & s_stb_o);
  assign hit_err = |(s_err_i & s_stb_o);
  assign hit_rty = |(s_rty_i & s_stb_o);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (s_stb_o[i]) begin
        rd_data = s_dat_i[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      slot    <= '0;
      cnt     <= '0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      s_cyc_o <= '0;
      s_stb_o <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            s_we_o  <= m_we_i;
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            s_sel_o <= m_sel_i;
            slot    <= m_adr_i[SLOT_LSB +: SLOT_BITS];
            state   <= DECODE;
          end
        end
        DECODE: begin
          cnt <= '0;
          if (!m_cyc_i) begin
            state <= IDLE;
          end else if (mapped) begin
            s_cyc_o <= dec_sel;
            s_stb_o <= dec_sel;
            state   <= ACCESS;
          end else begin
            m_err_o <= 1'b1;
            m_dat_o <= '0;
            state   <= RESP;
          end
        end
        ACCESS: begin
          cnt <= cnt + 16'd1;
          if (!m_cyc_i) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (hit_ack || hit_err || hit_rty) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            m_ack_o <= hit_ack;
            m_err_o <= !hit_ack && hit_err;
            m_rty_o <= !hit_ack && !hit_err;
            m_dat_o <= hit_ack ? rd_data : 32'd0;
            state   <= RESP;
          end else if (cnt == TMO_LAST) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            m_err_o <= 1'b1;
            m_dat_o <= '0;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_BUS_CTRL_STATS_EN
  // s_adr_o still holds the errored address while m_err_o is high in RESP.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_count <= '0;
      err_addr  <= '0;
    end else if (m_err_o) begin
      err_addr <= s_adr_o;
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_ctrl.sv
`default_nettype none
// tb_wb_bus_ctrl : randomized transactions against a cycle-budget
// transaction model of wb_bus_ctrl (NUM_SLV=4, TIMEOUT_CYC=16).
module tb_wb_bus_ctrl;
  localparam int NUM_SLV = 4;
  localparam int TMO     = 16;
  localparam logic [2:0] R_ACK = 3'b100;
  localparam logic [2:0] R_ERR = 3'b010;
  localparam logic [2:0] R_RTY = 3'b001;

  logic                  clk_clk = 1'b0;
  logic                  reset_reset_n = 1'b0;
  logic                  m_cyc_i = 1'b0;
  logic                  m_stb_i = 1'b0;
  logic                  m_we_i = 1'b0;
  logic [31:0]           m_adr_i = '0;
  logic [31:0]           m_dat_i = '0;
  logic [3:0]            m_sel_i = '0;
  logic [31:0]           m_dat_o;
  logic                  m_ack_o;
  logic                  m_err_o;
  logic                  m_rty_o;
  logic [NUM_SLV-1:0]    s_cyc_o;
  logic [NUM_SLV-1:0]    s_stb_o;
  logic                  s_we_o;
  logic [31:0]           s_adr_o;
  logic [31:0]           s_dat_o;
  logic [3:0]            s_sel_o;
  logic [32*NUM_SLV-1:0] s_dat_i = '0;
  logic [NUM_SLV-1:0]    s_ack_i = '0;
  logic [NUM_SLV-1:0]    s_err_i = '0;
  logic [NUM_SLV-1:0]    s_rty_i = '0;
`ifdef WB_BUS_CTRL_STATS_EN
  logic [15:0]           err_count;
  logic [31:0]           err_addr;
  int                    mdl_err_cnt = 0;
  logic [31:0]           mdl_err_adr = '0;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_dat = '0;

  wb_bus_ctrl #(
    .NUM_SLV(NUM_SLV), .SLOT_LSB(24), .SLOT_BITS(3), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
`ifdef WB_BUS_CTRL_STATS_EN
    .err_count(err_count), .err_addr(err_addr),
`endif
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transfer, entered and left on a negative edge. Cycle 0 is the cycle
  // the master first strobes. abort_at >= 0 drops m_cyc_i in that cycle.
  task automatic run_xfer(input logic [31:0] adr, input logic we,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int delay, input logic [2:0] rbits,
                          input int abort_at);
    int                 slot;
    int                 r;
    int                 last;
    bit                 mapped;
    bit                 aborted;
    logic [2:0]         exp_type;
    logic [2:0]         exp_pulse;
    logic [NUM_SLV-1:0] onehot;
    logic [NUM_SLV-1:0] exp_stb;
    logic [31:0]        sel_data;
    logic [31:0]        exp_dat;
    slot     = int'(adr[26:24]);
    mapped   = slot < NUM_SLV;
    aborted  = abort_at >= 0;
    onehot   = '0;
    if (mapped) onehot = NUM_SLV'(1) << slot;
    if (!mapped) begin
      r = 2; exp_type = R_ERR;
    end else if (rbits != 3'b000 && delay < TMO) begin
      r = 3 + delay;
      exp_type = rbits[2] ? R_ACK : (rbits[1] ? R_ERR : R_RTY);
    end else begin
      r = 2 + TMO; exp_type = R_ERR;
    end
    if (aborted) begin r = -1; last = abort_at + 3; end
    else last = r + 1;

    sel_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      s_dat_i[32*i +: 32] = $urandom;
      if (i == slot) sel_data = s_dat_i[32*i +: 32];
    end
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
    m_adr_i = adr; m_dat_i = dat; m_sel_i = sel;
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk_clk);
      exp_stb   = (c >= 2 && (aborted ? (c <= abort_at) : (c < r))) ? onehot : '0;
      exp_pulse = (c == r) ? exp_type : 3'b000;
      if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o} !== {exp_stb, exp_stb, exp_pulse}) begin
        $display("FAIL xfer_ctl adr=%h cycle %0d: got cyc=%b stb=%b ack/err/rty=%b%b%b, want stb=%b ack/err/rty=%b",
                 adr, c, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, exp_stb, exp_pulse);
        miscompares++;
      end
      vectors++;
      if (c == 1) begin
        if (m_dat_o !== last_dat) begin
          $display("FAIL rdata_hold adr=%h: got %h want %h", adr, m_dat_o, last_dat);
          miscompares++;
        end
        vectors++;
      end
      if (c == 2 || (!aborted && c == r + 1)) begin
        if ({s_we_o, s_adr_o, s_dat_o, s_sel_o} !== {we, adr, dat, sel}) begin
          $display("FAIL broadcast cycle %0d: got we=%b adr=%h dat=%h sel=%h want we=%b adr=%h dat=%h sel=%h",
                   c, s_we_o, s_adr_o, s_dat_o, s_sel_o, we, adr, dat, sel);
          miscompares++;
        end
        vectors++;
      end
      if (c == r) begin
        exp_dat = (exp_type == R_ACK) ? sel_data : 32'd0;
        if (m_dat_o !== exp_dat) begin
          $display("FAIL rdata adr=%h: got %h want %h", adr, m_dat_o, exp_dat);
          miscompares++;
        end
        vectors++;
        last_dat = exp_dat;
`ifdef WB_BUS_CTRL_STATS_EN
        if (exp_type == R_ERR) begin
          if (mdl_err_cnt < 65535) mdl_err_cnt++;
          mdl_err_adr = adr;
        end
`endif
      end
`ifdef WB_BUS_CTRL_STATS_EN
      if (!aborted && c == r + 1) begin
        if (err_count !== 16'(mdl_err_cnt) || err_addr !== mdl_err_adr) begin
          $display("FAIL stats: got cnt=%0d addr=%h want cnt=%0d addr=%h",
                   err_count, err_addr, mdl_err_cnt, mdl_err_adr);
          miscompares++;
        end
        vectors++;
      end
`endif
      // Unselected slaves chatter; only the addressed one answers for real.
      s_ack_i = NUM_SLV'($urandom) & ~onehot;
      s_err_i = NUM_SLV'($urandom) & ~onehot;
      s_rty_i = NUM_SLV'($urandom) & ~onehot;
      if (mapped && !aborted && c == 2 + delay) begin
        if (rbits[2]) s_ack_i = s_ack_i | onehot;
        if (rbits[1]) s_err_i = s_err_i | onehot;
        if (rbits[0]) s_rty_i = s_rty_i | onehot;
      end
      if (c == r || (aborted && c == abort_at)) begin
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        m_adr_i = $urandom; m_dat_i = $urandom; m_sel_i = 4'($urandom);
        m_we_i  = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_clk);
    if ({m_dat_o, m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o, s_we_o,
         s_adr_o, s_dat_o, s_sel_o} !== '0) begin
      $display("FAIL reset_state: outputs not all zero (stb=%b dat=%h)", s_stb_o, m_dat_o);
      miscompares++;
    end
    vectors++;
`ifdef WB_BUS_CTRL_STATS_EN
    if ({err_count, err_addr} !== '0) begin
      $display("FAIL reset_stats: got cnt=%0d addr=%h want 0", err_count, err_addr);
      miscompares++;
    end
    vectors++;
`endif
    reset_reset_n = 1'b1;
  endtask

  task automatic test_write_ack();
    run_xfer(32'h0100_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, R_ACK, -1);
  endtask

  task automatic test_read_ack();
    run_xfer(32'h0300_0000, 1'b0, 32'h0, 4'hF, 1, R_ACK, -1);
  endtask

  task automatic test_unmapped();
    run_xfer(32'h0500_0000, 1'b0, 32'h0, 4'hF, 0, R_ACK, -1);
  endtask

  task automatic test_timeout();
    run_xfer(32'h0000_0100, 1'b1, 32'h1111_2222, 4'h3, 100, 3'b000, -1);
  endtask

  task automatic test_priority();
    run_xfer(32'h0200_0004, 1'b0, 32'h0, 4'hF, 2, R_ACK | R_ERR, -1);
    run_xfer(32'h0200_0008, 1'b0, 32'h0, 4'hF, 0, R_RTY, -1);
    run_xfer(32'h0200_000C, 1'b1, 32'h5, 4'h1, 4, R_ERR | R_RTY, -1);
  endtask

  task automatic test_abort();
    run_xfer(32'h0100_0020, 1'b1, 32'hCAFE_0001, 4'hF, 0, 3'b000, 4);
    run_xfer(32'h0200_0020, 1'b0, 32'h0, 4'hF, 0, 3'b000, 1);
  endtask

  task automatic test_reset_mid();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1;
    m_adr_i = 32'h0000_0040; m_dat_i = 32'hA5A5_A5A5; m_sel_i = 4'hF;
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    repeat (3) @(negedge clk_clk);
    if (s_stb_o !== 4'b0001) begin
      $display("FAIL reset_mid_access: got stb=%b want 0001", s_stb_o);
      miscompares++;
    end
    vectors++;
    #2 reset_reset_n = 1'b0;
    #1;
    if ({m_dat_o, m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o, s_we_o,
         s_adr_o, s_dat_o, s_sel_o} !== '0) begin
      $display("FAIL reset_mid: outputs not cleared (stb=%b adr=%h)", s_stb_o, s_adr_o);
      miscompares++;
    end
    vectors++;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    last_dat = '0;
`ifdef WB_BUS_CTRL_STATS_EN
    mdl_err_cnt = 0;
    mdl_err_adr = '0;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] adr;
    int          abort_at;
    int          slot;
    for (int n = 0; n < 30; n++) begin
      slot = int'($urandom_range(0, 7));
      adr  = $urandom;
      adr[26:24] = 3'(slot);
      abort_at = (slot < NUM_SLV && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_xfer(adr, 1'($urandom), $urandom, 4'($urandom),
               int'($urandom_range(0, 20)), 3'($urandom_range(0, 7)), abort_at);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_ack();
    test_unmapped();
    test_timeout();
    test_priority();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
